// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Lets two cache controllers share the single four-bank main memory: the
//   instruction-cache FSM (I-side) and the data-cache FSM (D-side). Ownership
//   is granted for a whole transaction. A transaction can be an evict followed
//   by a fill, and a requester holds its req high for all of it.
//   While a side owns the memory, its address, data and strobes go to the
//   memory. Read data, bank busy, stall and error go back to the owner only.
//   When the owner releases, the arbiter waits DRAIN_CYC idle cycles before
//   making a new grant. During that drain, read data still returning from the
//   memory is routed to the previous owner.
//
// Parameters:
//   DRAIN_CYC  idle cycles between a release and the next grant (must be >= 1)
//   CNT_W      width of the drain counter (must hold DRAIN_CYC)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req/d_req                   transaction request, held for whole transaction
//   i_addr/d_addr                 requester address
//   i_data_in/d_data_in           requester write data
//   i_wr/d_wr, i_rd/d_rd          requester write / read strobes
//   m_data_out, m_busy            memory read data, per-bank busy
//   m_stall, m_err                memory stall, memory error
//   m_addr, m_data_in             address / write data to memory
//   m_wr, m_rd                    strobes to memory
//   i_gnt/d_gnt                   side currently owns the memory
//   i_data_out/d_data_out         read data routed to each side
//   i_busy/d_busy                 bank busy seen by each side (4'hF when not owner)
//   i_stall/d_stall               stall to each side
//   i_err/d_err                   memory or protocol error to each side
//   arb_state                     current state (IDLE=00 GNT_I=01 GNT_D=10 DRAIN=11)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    input  logic        i_wr,
    input  logic        i_rd,

    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_wr,
    input  logic        d_rd,

    input  logic [15:0] m_data_out,
    input  logic [3:0]  m_busy,
    input  logic        m_stall,
    input  logic        m_err,

    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_wr,
    output logic        m_rd,

    output logic        i_gnt,
    output logic        d_gnt,
    output logic [15:0] i_data_out,
    output logic [15:0] d_data_out,
    output logic [3:0]  i_busy,
    output logic [3:0]  d_busy,
    output logic        i_stall,
    output logic        d_stall,
    output logic        i_err,
    output logic        d_err,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10,
        DRAIN = 2'b11
    } state_t;

    // Side encoding, used for last_owner and for the response / grant owner.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    // -------------------------------------------------------------------------
    // Arbitration decision, shared by IDLE and the last cycle of DRAIN.
    // On a tie, the side that did not own the memory last wins.
    // -------------------------------------------------------------------------
    state_t arb_pick;

    always_comb begin
        arb_pick = IDLE;
        if (i_req && d_req) begin
            arb_pick = (last_q == SIDE_I) ? GNT_D : GNT_I;
        end else if (i_req) begin
            arb_pick = GNT_I;
        end else if (d_req) begin
            arb_pick = GNT_D;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= SIDE_I;   // so the D-side wins the first tie
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state. An owner keeps the memory until it drops its req.
    // The other side's req is ignored until the drain has finished.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                state_d = arb_pick;
            end
            GNT_I: begin
                if (!i_req) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    last_d  = SIDE_I;
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    last_d  = SIDE_D;
                end
            end
            DRAIN: begin
                // The counter reads 1 in the final drain cycle. The next grant
                // is decided then, so no extra cycle is spent in IDLE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = arb_pick;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Ownership decode.
    // grant_*: the side whose strobes reach the memory (GNT_x only).
    // resp_*:  the side that receives memory responses. This includes the
    //          previous owner during DRAIN, so that late read data reaches it.
    // -------------------------------------------------------------------------
    logic grant_vld;
    logic grant_side;
    logic resp_vld;
    logic resp_side;

    always_comb begin
        grant_vld  = (state_q == GNT_I) || (state_q == GNT_D);
        grant_side = (state_q == GNT_D) ? SIDE_D : SIDE_I;
        resp_vld   = grant_vld || (state_q == DRAIN);
        resp_side  = grant_vld ? grant_side : last_q;
    end

    // -------------------------------------------------------------------------
    // Memory-side mux
    // -------------------------------------------------------------------------
    logic [15:0] sel_addr;
    logic [15:0] sel_data;
    logic        sel_wr;
    logic        sel_rd;
    logic        proto_err;

    always_comb begin
        sel_addr  = (grant_side == SIDE_D) ? d_addr    : i_addr;
        sel_data  = (grant_side == SIDE_D) ? d_data_in : i_data_in;
        sel_wr    = (grant_side == SIDE_D) ? d_wr      : i_wr;
        sel_rd    = (grant_side == SIDE_D) ? d_rd      : i_rd;
        // Read and write strobed together is a protocol error. Both strobes
        // are suppressed so that the memory never sees an ambiguous command.
        proto_err = grant_vld && sel_wr && sel_rd;
    end

    always_comb begin
        m_addr    = grant_vld ? sel_addr : '0;
        m_data_in = grant_vld ? sel_data : '0;
        m_wr      = grant_vld && sel_wr && !sel_rd;
        m_rd      = grant_vld && sel_rd && !sel_wr;
    end

    // -------------------------------------------------------------------------
    // Per-side return routing. Index 0 is the I-side and index 1 is the D-side.
    // -------------------------------------------------------------------------
    logic [1:0]  side_req;
    logic [15:0] side_data_out [2];
    logic [3:0]  side_busy     [2];
    logic [1:0]  side_stall;
    logic [1:0]  side_err;

    assign side_req = {d_req, i_req};

    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        localparam logic SIDE = (gi == 1) ? SIDE_D : SIDE_I;

        logic is_resp;
        logic is_gnt;

        assign is_resp = resp_vld  && (resp_side  == SIDE);
        assign is_gnt  = grant_vld && (grant_side == SIDE);

        assign side_data_out[gi] = is_resp ? m_data_out : 16'h0000;
        // A non-owner sees every bank as busy, so it never starts an access.
        assign side_busy[gi]     = is_resp ? m_busy : 4'hF;
        assign side_err[gi]      = is_resp && (m_err || (is_gnt && proto_err));
        // Only the granted side follows the memory stall. Any other side that
        // is requesting is held off until it is granted, and this includes a
        // previous owner that re-requests during DRAIN.
        assign side_stall[gi]    = is_gnt ? m_stall : side_req[gi];
    end

    assign i_data_out = side_data_out[0];
    assign d_data_out = side_data_out[1];
    assign i_busy     = side_busy[0];
    assign d_busy     = side_busy[1];
    assign i_err      = side_err[0];
    assign d_err      = side_err[1];
    assign i_stall    = side_stall[0];
    assign d_stall    = side_stall[1];

    assign i_gnt      = (state_q == GNT_I);
    assign d_gnt      = (state_q == GNT_D);
    assign arb_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural model tracks who owns the
// memory, how many drain cycles are left and who owned it last. Every cycle,
// each DUT output is compared against what that model implies. Directed
// sequences add literal expectations, and randomized traffic follows them.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DRAIN_CYC = 2;
    localparam int NONE = 0;
    localparam int SI   = 1;
    localparam int SD   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, i_rd;
    logic [15:0] i_addr, i_data_in;
    logic        d_req, d_wr, d_rd;
    logic [15:0] d_addr, d_data_in;
    logic [15:0] m_data_out;
    logic [3:0]  m_busy;
    logic        m_stall, m_err;

    logic [15:0] m_addr, m_data_in;
    logic        m_wr, m_rd;
    logic        i_gnt, d_gnt;
    logic [15:0] i_data_out, d_data_out;
    logic [3:0]  i_busy, d_busy;
    logic        i_stall, d_stall, i_err, d_err;
    logic [1:0]  arb_state;

    always #5 clk = ~clk;

    mem_arbiter #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in), .i_wr(i_wr), .i_rd(i_rd),
        .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in), .d_wr(d_wr), .d_rd(d_rd),
        .m_data_out(m_data_out), .m_busy(m_busy), .m_stall(m_stall), .m_err(m_err),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .i_data_out(i_data_out), .d_data_out(d_data_out),
        .i_busy(i_busy), .d_busy(d_busy),
        .i_stall(i_stall), .d_stall(d_stall),
        .i_err(i_err), .d_err(d_err),
        .arb_state(arb_state)
    );

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 0;

    // Behavioural model: owner of the memory, drain cycles left, last owner.
    int mdl_owner = NONE;
    int mdl_drain = 0;
    int mdl_last  = SI;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic ir, input logic dr, input int last);
        if (ir && dr) return (last == SI) ? SD : SI;
        if (ir) return SI;
        if (dr) return SD;
        return NONE;
    endfunction

    task automatic model_check();
        int          resp;
        logic [1:0]  exp_state;
        logic        ow_wr, ow_rd, pe;
        logic [15:0] ow_addr, ow_data;
        resp      = (mdl_owner != NONE) ? mdl_owner : ((mdl_drain > 0) ? mdl_last : NONE);
        exp_state = (mdl_owner == SI) ? 2'd1 : (mdl_owner == SD) ? 2'd2 :
                    (mdl_drain > 0) ? 2'd3 : 2'd0;
        ow_wr = 1'b0; ow_rd = 1'b0; ow_addr = 16'h0; ow_data = 16'h0;
        if (mdl_owner == SI) begin
            ow_wr = i_wr; ow_rd = i_rd; ow_addr = i_addr; ow_data = i_data_in;
        end else if (mdl_owner == SD) begin
            ow_wr = d_wr; ow_rd = d_rd; ow_addr = d_addr; ow_data = d_data_in;
        end
        pe = ow_wr & ow_rd;
        chk("arb_state", 16'(arb_state), 16'(exp_state));
        chk("i_gnt", 16'(i_gnt), 16'(mdl_owner == SI));
        chk("d_gnt", 16'(d_gnt), 16'(mdl_owner == SD));
        chk("m_addr", m_addr, ow_addr);
        chk("m_data_in", m_data_in, ow_data);
        chk("m_wr", 16'(m_wr), 16'(ow_wr & ~pe));
        chk("m_rd", 16'(m_rd), 16'(ow_rd & ~pe));
        chk("i_data_out", i_data_out, (resp == SI) ? m_data_out : 16'h0);
        chk("d_data_out", d_data_out, (resp == SD) ? m_data_out : 16'h0);
        chk("i_busy", 16'(i_busy), 16'((resp == SI) ? m_busy : 4'hF));
        chk("d_busy", 16'(d_busy), 16'((resp == SD) ? m_busy : 4'hF));
        chk("i_err", 16'(i_err), 16'((resp == SI) && (m_err || (mdl_owner == SI && pe))));
        chk("d_err", 16'(d_err), 16'((resp == SD) && (m_err || (mdl_owner == SD && pe))));
        chk("i_stall", 16'(i_stall), 16'((mdl_owner == SI) ? m_stall : i_req));
        chk("d_stall", 16'(d_stall), 16'((mdl_owner == SD) ? m_stall : d_req));
    endtask

    task automatic model_step();
        if (rst) begin
            mdl_owner = NONE; mdl_drain = 0; mdl_last = SI;
        end else if (mdl_owner != NONE) begin
            if (!((mdl_owner == SI) ? i_req : d_req)) begin
                mdl_last  = mdl_owner;
                mdl_owner = NONE;
                mdl_drain = DRAIN_CYC;
            end
        end else if (mdl_drain > 0) begin
            if (mdl_drain == 1) begin
                mdl_drain = 0;
                mdl_owner = pick(i_req, d_req, mdl_last);
            end else begin
                mdl_drain--;
            end
        end else begin
            mdl_owner = pick(i_req, d_req, mdl_last);
        end
    endtask

    // Inputs are changed just after the falling edge. Outputs are checked 1 ns later.
    task automatic settle();
        #1;
        if (chk_en) model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_wr = 0; i_rd = 0; i_addr = 0; i_data_in = 0;
        d_req = 0; d_wr = 0; d_rd = 0; d_addr = 0; d_data_in = 0;
        m_data_out = 0; m_busy = 0; m_stall = 0; m_err = 0;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs();
        settle(); advance();
        chk_en = 1;
        settle();
        chk("rst_state", 16'(arb_state), 16'h0);
        chk("rst_i_busy", 16'(i_busy), 16'hF);
        chk("rst_d_busy", 16'(d_busy), 16'hF);
        chk("rst_gnt", 16'({i_gnt, d_gnt}), 16'h0);
        chk("rst_m_wr", 16'(m_wr), 16'h0);
        advance();
        rst = 0;
    endtask

    task automatic wait_gnt(output int who);
        int n;
        who = NONE; n = 0;
        while (who == NONE && n < 20) begin
            settle();
            if (i_gnt) who = SI;
            else if (d_gnt) who = SD;
            else begin advance(); n++; end
        end
        if (who == NONE) begin
            compared++; mismatched++;
            $display("FAIL wait_gnt: no grant within 20 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        int who;
        rst = 1; clear_inputs();
        @(negedge clk);

        // --- lone I read ---
        do_reset();
        settle(); advance();
        i_req = 1; i_rd = 1; i_addr = 16'h0040;
        settle();
        chk("t1_pre_gnt", 16'(i_gnt), 16'h0);
        chk("t1_pre_stall", 16'(i_stall), 16'h1);
        advance(); settle();
        chk("t1_i_gnt", 16'(i_gnt), 16'h1);
        chk("t1_m_rd", 16'(m_rd), 16'h1);
        chk("t1_m_addr", m_addr, 16'h0040);
        chk("t1_d_busy", 16'(d_busy), 16'hF);
        advance();
        i_req = 0; i_rd = 0;
        settle(); advance();

        // --- round robin D,I,D,I ---
        do_reset();
        i_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(who);
            chk("rr_order", 16'(who), 16'((k % 2 == 0) ? SD : SI));
            advance(); settle(); advance();
            if (who == SD) d_req = 0; else i_req = 0;
            settle(); advance();
            i_req = 1; d_req = 1;
            settle();
            chk("rr_drain", 16'(arb_state), 16'h3);
            advance();
        end
        i_req = 0; d_req = 0;
        for (int k = 0; k < 6; k++) begin settle(); advance(); end

        // --- non-owner strobes dropped; read return during drain ---
        do_reset();
        d_req = 1;
        settle(); advance();
        d_rd = 1; d_addr = 16'h0010;
        i_req = 1; i_wr = 1; i_addr = 16'h1234; m_data_out = 16'h5A5A;
        settle();
        chk("t3_m_wr", 16'(m_wr), 16'h0);
        chk("t3_m_addr", m_addr, 16'h0010);
        chk("t3_i_stall", 16'(i_stall), 16'h1);
        chk("t3_i_data", i_data_out, 16'h0);
        chk("t3_d_data", d_data_out, 16'h5A5A);
        i_wr = 0; d_addr = 16'h0008;
        settle();
        chk("t4_m_addr", m_addr, 16'h0008);
        advance();
        d_req = 0; d_rd = 0;
        settle();
        chk("t4_d_gnt", 16'(d_gnt), 16'h1);
        advance();
        m_data_out = 16'hBEEF;
        settle();
        chk("t4_drain", 16'(arb_state), 16'h3);
        chk("t4_d_data", d_data_out, 16'hBEEF);
        chk("t4_i_data", i_data_out, 16'h0);
        advance(); settle(); advance();
        m_data_out = 16'h0;
        settle();
        chk("t4_i_gnt_after_drain", 16'(i_gnt), 16'h1);

        // --- protocol error and memory error routing (I owns) ---
        i_rd = 1; i_wr = 1;
        settle();
        chk("t5_m_rd", 16'(m_rd), 16'h0);
        chk("t5_m_wr", 16'(m_wr), 16'h0);
        chk("t5_i_err", 16'(i_err), 16'h1);
        chk("t5_d_err", 16'(d_err), 16'h0);
        advance();
        i_wr = 0;
        settle();
        chk("t5_i_err_clear", 16'(i_err), 16'h0);
        m_err = 1;
        settle();
        chk("t5_m_err_i", 16'(i_err), 16'h1);
        chk("t5_m_err_d", 16'(d_err), 16'h0);
        advance();
        m_err = 0;

        // --- reset mid-transaction ---
        i_rd = 0; i_wr = 1; rst = 1;
        settle();
        chk("t6_pre_m_wr", 16'(m_wr), 16'h1);
        advance();
        rst = 0;
        settle();
        chk("t6_state", 16'(arb_state), 16'h0);
        chk("t6_m_wr", 16'(m_wr), 16'h0);
        chk("t6_i_gnt", 16'(i_gnt), 16'h0);
        advance(); settle();
        chk("t6_regrant", 16'(i_gnt), 16'h1);
        advance();

        // --- randomized traffic ---
        clear_inputs();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(255) == 0);
            if ($urandom_range(7) == 0) i_req = ~i_req;
            if ($urandom_range(7) == 0) d_req = ~d_req;
            i_wr = 1'($urandom_range(3) == 0); i_rd = 1'($urandom_range(1));
            d_wr = 1'($urandom_range(3) == 0); d_rd = 1'($urandom_range(1));
            i_addr = 16'($urandom); i_data_in = 16'($urandom);
            d_addr = 16'($urandom); d_data_in = 16'($urandom);
            m_data_out = 16'($urandom); m_busy = 4'($urandom);
            m_stall = 1'($urandom_range(1)); m_err = ($urandom_range(15) == 0);
            settle(); advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
